alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal 2..32).
REQ-002 The block SHALL have derived constant RW = 2*WIDTH, giving the result width.
REQ-003 Port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  in  1  SHALL be a synchronous, active-low reset.
REQ-005 Port in_valid  in  1  command present.
REQ-006 Port in_ready  out  1  block can accept a command.
REQ-007 Port a  in  WIDTH  signed two's-complement operand A.
REQ-008 Port b  in  WIDTH  signed two's-complement operand B.
REQ-009 Port sel  in  4  opcode.
REQ-010 Port out_valid  out  1  result present.
REQ-011 Port out_ready  in  1  consumer takes result.
REQ-012 Port result  out  RW  signed result.
REQ-013 Port flag_zero  out  1  result == 0.
REQ-014 Port flag_neg  out  1  result MSB.
REQ-015 Port flag_err  out  1  reserved opcode executed.

Function
REQ-016 Acceptance SHALL occur on an edge where in_valid && in_ready; a, b and sel SHALL be captured at that edge.
REQ-017 Delivery SHALL occur on an edge where out_valid && out_ready.
REQ-018 The FSM SHALL have states IDLE, MUL and HOLD; in_ready SHALL be 1 only in IDLE.
REQ-019 IDLE SHALL go to HOLD on acceptance of any non-MUL opcode; result and flags SHALL be registered at that edge, so out_valid=1 on the next cycle (latency 1).
REQ-020 IDLE SHALL go to MUL on acceptance of opcode MUL.
REQ-021 MUL SHALL run for exactly WIDTH cycles, then go to HOLD, so out_valid rises WIDTH+1 cycles after acceptance.
REQ-022 HOLD SHALL return to IDLE on delivery.
REQ-023 In HOLD, result and flags SHALL stay stable while out_ready=0.
REQ-024 A new command SHALL NOT be accepted in the delivery cycle; throughput is 1 command per 2 cycles minimum.
REQ-025 Opcodes 0 ADD and 1 SUB SHALL sign-extend both operands and compute at full precision (no overflow possible in RW).
REQ-026 Opcodes 2 AND, 3 OR, 4 XOR and 5 NOT(a) SHALL zero-extend their WIDTH-bit result to RW.
REQ-027 Opcodes 6 SHL and 7 SHR (logical) SHALL shift a by b[log2(WIDTH)-1:0] within WIDTH bits, then zero-extend.
REQ-028 Opcode 8 ASR SHALL arithmetic-shift a by the same amount, then sign-extend.
REQ-029 Opcode 9 MUL SHALL compute the signed product a*b, exact in RW bits, by iterative shift-add over |a| and |b| with a final sign correction; -2^(WIDTH-1) * -2^(WIDTH-1) SHALL be exact.
REQ-030 Opcode 10 CMP SHALL give result = 1 if a<b signed, else 0.
REQ-031 Opcode 11 ACC_ADD SHALL set acc <= acc + sext(a), wrapping modulo 2^RW, with result = the new acc.
REQ-032 Opcode 12 ACC_CLR SHALL set acc <= 0 with result = 0.
REQ-033 Opcode 12 ACC_CLR SHALL take effect when the command is accepted.
REQ-034 acc SHALL be RW bits and SHALL persist across commands.
REQ-035 Opcodes 13-15 SHALL give result=0 and flag_err=1; flag_err SHALL be 0 for all other opcodes.
REQ-036 flag_zero and flag_neg SHALL be derived from the registered result and SHALL be valid whenever out_valid=1.

Reset
REQ-037 When rst_n=0 at an edge, the FSM SHALL go to IDLE and acc, result and all flags SHALL be set to 0.
REQ-038 When rst_n=0 at an edge, out_valid SHALL be 0.
REQ-039 When rst_n=0 at an edge, in_ready SHALL be 0 during reset and 1 on the first cycle after release.
REQ-040 A reset asserted during MUL or HOLD SHALL abort the operation with no result delivered and SHALL also clear acc.

Structure
REQ-041 Package alu_seq_pkg SHALL hold the opcode enum (ADD..ACC_CLR), the FSM state enum and the helper function clog2.
REQ-042 The iterative multiplier SHALL be sub-module alu_seq_mul, with ports start, a, b, done and product, parameterised by WIDTH.

Verification
REQ-043 WIDTH=8, ADD a=-128 b=-1 -> result=-129, flag_neg=1, out_valid one cycle after acceptance.
REQ-044 WIDTH=8, MUL a=-3 b=5 -> result=-15 at acceptance+9 cycles; MUL a=-128 b=-128 -> result=16384.
REQ-045 ACC_CLR, then ACC_ADD a=100 three times -> results 100, 200, 300; then ACC_CLR -> result 0, flag_zero=1.
REQ-046 Hold out_ready=0 for 5 cycles after SUB a=2 b=3 -> result=-1 stable, in_ready=0 throughout, single delivery on release.
REQ-047 Assert rst_n=0 at MUL cycle 4 -> out_valid never rises, acc=0, in_ready=1 after release; sel=13 -> result=0, flag_err=1.
REQ-048 WIDTH=2, exhaustive sweep of all a, b and sel (256 commands) against a reference model -> zero mismatches.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU, plus a
// constant-foldable ceil(log2) used to size shift and counter fields.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_AND     = 4'd2,
    OP_OR      = 4'd3,
    OP_XOR     = 4'd4,
    OP_NOT     = 4'd5,
    OP_SHL     = 4'd6,
    OP_SHR     = 4'd7,
    OP_ASR     = 4'd8,
    OP_MUL     = 4'd9,
    OP_CMP     = 4'd10,
    OP_ACC_ADD = 4'd11,
    OP_ACC_CLR = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier over operand magnitudes with a final
// sign fix; done is asserted during the last step so product is ready that edge.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = clog2(WIDTH + 1);

  logic [RW-1:0]    acc_p;
  logic [RW-1:0]    mcand;
  logic [RW-1:0]    sum;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic             busy;

  // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  assign mag_a   = a[WIDTH-1] ? -a : a;
  assign mag_b   = b[WIDTH-1] ? -b : b;
  assign sum     = acc_p + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == CW'(1));
  assign product = neg ? -sum : sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc_p  <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(WIDTH);
      acc_p  <= '0;
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
      neg    <= a[WIDTH-1] ^ b[WIDTH-1];
    end else if (busy) begin
      acc_p  <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: one command at a time, single-cycle ops plus an iterative
// multiply, with a persistent accumulator and a ready/valid result hold.
//   state  | meaning
//   S_IDLE | waiting for a command (in_ready=1 except first cycle after reset)
//   S_MUL  | iterative multiply in progress
//   S_HOLD | result valid, waiting for out_ready
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_zero,
  output logic                 flag_neg,
  output logic                 flag_err
);

  localparam int RW = 2 * WIDTH;
  localparam int SW = clog2(WIDTH);

  state_e           state;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    alu_res;
  logic             alu_err;
  logic [RW-1:0]    sa;
  logic [RW-1:0]    sb;
  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] shl_v;
  logic [WIDTH-1:0] shr_v;
  logic [WIDTH-1:0] asr_v;
  logic             accept;
  logic             deliver;
  logic             mul_start;
  logic             mul_done;
  logic [RW-1:0]    mul_product;

  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  assign mul_start = accept && (sel == OP_MUL);

  assign sa    = {{WIDTH{a[WIDTH-1]}}, a};
  assign sb    = {{WIDTH{b[WIDTH-1]}}, b};
  assign sh    = b[SW-1:0];
  assign shl_v = a << sh;
  assign shr_v = a >> sh;
  assign asr_v = $signed(a) >>> sh;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (sel)
      OP_ADD:     alu_res = sa + sb;
      OP_SUB:     alu_res = sa - sb;
      OP_AND:     alu_res = {{WIDTH{1'b0}}, a & b};
      OP_OR:      alu_res = {{WIDTH{1'b0}}, a | b};
      OP_XOR:     alu_res = {{WIDTH{1'b0}}, a ^ b};
      OP_NOT:     alu_res = {{WIDTH{1'b0}}, ~a};
      OP_SHL:     alu_res = {{WIDTH{1'b0}}, shl_v};
      OP_SHR:     alu_res = {{WIDTH{1'b0}}, shr_v};
      OP_ASR:     alu_res = {{WIDTH{asr_v[WIDTH-1]}}, asr_v};
      OP_CMP:     alu_res = RW'($signed(a) < $signed(b));
      OP_ACC_ADD: alu_res = acc + sa;
      OP_ACC_CLR: alu_res = '0;
      OP_MUL:     alu_res = '0;
      default:    alu_err = 1'b1;
    endcase
  end

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      acc       <= '0;
      result    <= '0;
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
      flag_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            in_ready <= 1'b0;
            if (sel == OP_MUL) begin
              state <= S_MUL;
            end else begin
              state     <= S_HOLD;
              out_valid <= 1'b1;
              result    <= alu_res;
              flag_zero <= (alu_res == '0);
              flag_neg  <= alu_res[RW-1];
              flag_err  <= alu_err;
              if (sel == OP_ACC_ADD || sel == OP_ACC_CLR) acc <= alu_res;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            state     <= S_HOLD;
            out_valid <= 1'b1;
            result    <= mul_product;
            flag_zero <= (mul_product == '0);
            flag_neg  <= mul_product[RW-1];
            flag_err  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (deliver) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: WIDTH=8 scenarios with hand-computed results and
// an exhaustive WIDTH=2 sweep against a small integer model.
module tb_alu_seq;

  typedef struct {
    logic [3:0]  s;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] r;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [3:0]  sel;
  logic [15:0] result;
  logic        flag_zero, flag_neg, flag_err;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [1:0]  a2, b2;
  logic [3:0]  sel2;
  logic [3:0]  result2;
  logic        flag_zero2, flag_neg2, flag_err2;

  int vectors = 0;
  int miscompares = 0;

  vec_t ops_tbl [12] = '{
    '{4'd2,  8'hF0, 8'h3C, 16'h0030},
    '{4'd3,  8'hF0, 8'h0C, 16'h00FC},
    '{4'd4,  8'hFF, 8'h0F, 16'h00F0},
    '{4'd5,  8'h0F, 8'h00, 16'h00F0},
    '{4'd6,  8'h81, 8'h01, 16'h0002},
    '{4'd6,  8'h01, 8'h09, 16'h0002},
    '{4'd7,  8'h81, 8'h03, 16'h0010},
    '{4'd8,  8'h81, 8'h03, 16'hFFF0},
    '{4'd10, 8'hFF, 8'h01, 16'h0001},
    '{4'd10, 8'h01, 8'hFF, 16'h0000},
    '{4'd0,  8'h7F, 8'h7F, 16'h00FE},
    '{4'd1,  8'h80, 8'h7F, 16'hFF01}
  };

  vec_t mul_tbl [4] = '{
    '{4'd9, 8'hFD, 8'h05, 16'hFFF1},
    '{4'd9, 8'h80, 8'h80, 16'h4000},
    '{4'd9, 8'h7F, 8'h80, 16'hC080},
    '{4'd9, 8'h00, 8'hFB, 16'h0000}
  };

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_zero(flag_zero), .flag_neg(flag_neg), .flag_err(flag_err)
  );

  alu_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .sel(sel2), .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .flag_zero(flag_zero2), .flag_neg(flag_neg2), .flag_err(flag_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: all return at a negedge, the sampling point.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_ready got=%b want=1", in_ready);
    end
    sel = s; a = x; b = y; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic deliver();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hs got in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    vectors++;
    if (result !== 16'h0 || flag_zero !== 1'b0 || flag_neg !== 1'b0 || flag_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got r=%h z=%b n=%b e=%b want 0000 0 0 0", result, flag_zero, flag_neg, flag_err);
    end
    rst_n = 1'b1;
    cycle();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_add();
    int lat;
    send(4'd0, 8'h80, 8'hFF);
    wait_out(lat);
    vectors++;
    if (lat !== 1 || result !== 16'hFF7F || flag_neg !== 1'b1 || flag_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL add_neg got r=%h n=%b z=%b lat=%0d want ff7f 1 0 lat=1", result, flag_neg, flag_zero, lat);
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL add_busy got in_ready=%b want 0", in_ready);
    end
    deliver();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL add_deliver got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ops();
    int lat;
    for (int i = 0; i < 12; i++) begin
      send(ops_tbl[i].s, ops_tbl[i].x, ops_tbl[i].y);
      wait_out(lat);
      vectors++;
      if (lat !== 1 || result !== ops_tbl[i].r || flag_zero !== (ops_tbl[i].r == 16'h0) ||
          flag_neg !== ops_tbl[i].r[15] || flag_err !== 1'b0) begin
        miscompares++;
        $display("FAIL ops[%0d] got r=%h z=%b n=%b e=%b lat=%0d want r=%h lat=1",
                 i, result, flag_zero, flag_neg, flag_err, lat, ops_tbl[i].r);
      end
      deliver();
    end
  endtask

  task automatic test_mul();
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(mul_tbl[i].s, mul_tbl[i].x, mul_tbl[i].y);
      wait_out(lat);
      vectors++;
      if (lat !== 9 || result !== mul_tbl[i].r || flag_zero !== (mul_tbl[i].r == 16'h0) ||
          flag_neg !== mul_tbl[i].r[15] || flag_err !== 1'b0) begin
        miscompares++;
        $display("FAIL mul[%0d] got r=%h z=%b n=%b e=%b lat=%0d want r=%h lat=9",
                 i, result, flag_zero, flag_neg, flag_err, lat, mul_tbl[i].r);
      end
      deliver();
    end
  endtask

  task automatic test_acc();
    int lat;
    logic [15:0] exp_r;
    send(4'd12, 8'h00, 8'h00);
    wait_out(lat);
    deliver();
    for (int i = 1; i <= 3; i++) begin
      exp_r = 16'(i * 100);
      send(4'd11, 8'd100, 8'h00);
      wait_out(lat);
      vectors++;
      if (lat !== 1 || result !== exp_r || flag_zero !== 1'b0) begin
        miscompares++;
        $display("FAIL acc_add[%0d] got r=%0d z=%b lat=%0d want r=%0d", i, result, flag_zero, lat, exp_r);
      end
      deliver();
    end
    send(4'd12, 8'h55, 8'h00);
    wait_out(lat);
    vectors++;
    if (result !== 16'h0 || flag_zero !== 1'b1 || flag_neg !== 1'b0) begin
      miscompares++;
      $display("FAIL acc_clr got r=%h z=%b n=%b want 0000 1 0", result, flag_zero, flag_neg);
    end
    deliver();
    send(4'd11, 8'hFE, 8'h00);
    wait_out(lat);
    vectors++;
    if (result !== 16'hFFFE || flag_neg !== 1'b1) begin
      miscompares++;
      $display("FAIL acc_after_clr got r=%h n=%b want fffe 1", result, flag_neg);
    end
    deliver();
  endtask

  task automatic test_hold();
    int lat;
    int extra;
    send(4'd1, 8'd2, 8'd3);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || result !== 16'hFFFF || in_ready !== 1'b0 || flag_neg !== 1'b1) begin
        miscompares++;
        $display("FAIL hold[%0d] got v=%b r=%h rdy=%b n=%b want 1 ffff 0 1", i, out_valid, result, in_ready, flag_neg);
      end
      sel = 4'd0; a = 8'd1; b = 8'd1; in_valid = 1'b1;
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (out_valid) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL hold_single got extra_valid=%0d want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int hits;
    int bad;
    hits = 0;
    bad = 0;
    out_ready = 1'b1;
    sel = 4'd0; a = 8'd1; b = 8'd2; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (out_valid) begin
        hits++;
        if (result !== 16'd3) bad++;
      end
    end
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b0;
    vectors++;
    if (hits !== 5 || bad !== 0) begin
      miscompares++;
      $display("FAIL back_to_back got deliveries=%0d bad=%0d want 5 0", hits, bad);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    send(4'd11, 8'd5, 8'd0);
    wait_out(lat);
    deliver();
    send(4'd9, 8'd3, 8'd3);
    cycle();
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_mid got v=%b rdy=%b r=%h want 0 0 0000", out_valid, in_ready, result);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (out_valid) seen++;
    end
    vectors++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_abort got valid_cycles=%0d rdy=%b want 0 1", seen, in_ready);
    end
    send(4'd11, 8'd0, 8'd0);
    wait_out(lat);
    vectors++;
    if (result !== 16'h0 || flag_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_acc got r=%h z=%b want 0000 1", result, flag_zero);
    end
    deliver();
    send(4'd13, 8'h12, 8'h34);
    wait_out(lat);
    vectors++;
    if (result !== 16'h0 || flag_err !== 1'b1 || lat !== 1) begin
      miscompares++;
      $display("FAIL reserved_op got r=%h e=%b lat=%0d want 0000 1 1", result, flag_err, lat);
    end
    deliver();
    send(4'd0, 8'd1, 8'd1);
    wait_out(lat);
    vectors++;
    if (result !== 16'd2 || flag_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clears got r=%h e=%b want 0002 0", result, flag_err);
    end
    deliver();
  endtask

  task automatic test_sweep_w2();
    int macc, sx, sy, r, err, exp_lat, lat, guard;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    macc = 0;
    for (int s = 0; s < 16; s++) begin
      for (int x = 0; x < 4; x++) begin
        for (int y = 0; y < 4; y++) begin
          sx = (x >= 2) ? x - 4 : x;
          sy = (y >= 2) ? y - 4 : y;
          err = 0;
          exp_lat = 1;
          case (s)
            0:  r = sx + sy;
            1:  r = sx - sy;
            2:  r = x & y;
            3:  r = x | y;
            4:  r = x ^ y;
            5:  r = ~x & 3;
            6:  r = (x << (y & 1)) & 3;
            7:  r = x >> (y & 1);
            8:  r = sx >>> (y & 1);
            9:  begin r = sx * sy; exp_lat = 3; end
            10: r = (sx < sy) ? 1 : 0;
            11: begin macc = (macc + sx) & 15; r = macc; end
            12: begin macc = 0; r = 0; end
            default: begin r = 0; err = 1; end
          endcase
          r = r & 15;
          guard = 0;
          while (!in_ready2 && guard < 20) begin
            @(negedge clk);
            guard++;
          end
          sel2 = 4'(s); a2 = 2'(x); b2 = 2'(y); in_valid2 = 1'b1;
          cycle();
          in_valid2 = 1'b0;
          lat = 1;
          while (!out_valid2 && lat < 20) begin
            @(negedge clk);
            lat++;
          end
          vectors++;
          if (result2 !== 4'(r) || flag_zero2 !== (r == 0) || flag_neg2 !== r[3] ||
              flag_err2 !== (err == 1) || lat !== exp_lat) begin
            miscompares++;
            $display("FAIL w2 sel=%0d a=%0d b=%0d got r=%h z=%b n=%b e=%b lat=%0d want r=%h e=%0d lat=%0d",
                     s, x, y, result2, flag_zero2, flag_neg2, flag_err2, lat, 4'(r), err, exp_lat);
          end
          out_ready2 = 1'b1;
          cycle();
          out_ready2 = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; sel2 = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_ops();
    test_mul();
    test_acc();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_sweep_w2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
